// File: rtl/edge_pixel_loader.sv
`default_nettype none
// ============================================================================
// edge_pixel_loader : Avalon-ST sink writing one grayscale frame into image RAM
// Rev 1.0
// ============================================================================
module edge_pixel_loader #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_en_i,
  input  logic [PIX_W-1:0]  snk_data_i,
  input  logic              snk_valid_i,
  input  logic              snk_sop_i,
  input  logic              snk_eop_i,
  output logic              snk_ready_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PIX_W-1:0]  mem_data_o,
  output logic              input_received_o,
  output logic              frame_err_o
);

  localparam int                c_N    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_N - 1);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOP = 3'd1,
    S_LOAD     = 3'd2,
    S_FLUSH    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic                w_accept;

  // Ready decodes state only, so upstream sees zero ready latency.
  assign snk_ready_o = (state_q == S_WAIT_SOP) || (state_q == S_LOAD);
  assign w_accept    = snk_valid_i & snk_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (load_en_i) begin
          state_d = S_WAIT_SOP;
          err_d   = 1'b0;
        end
      end

      S_WAIT_SOP: begin
        if (!load_en_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (w_accept) begin
          if (snk_sop_i) begin
            wr_d   = 1'b1;
            addr_d = '0;
            data_d = snk_data_i;
            if (c_N == 1) begin
              state_d = S_FLUSH;
              cnt_d   = '0;
              if (!snk_eop_i) err_d = 1'b1;
            end else begin
              state_d = S_LOAD;
              cnt_d   = c_ONE;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (!load_en_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (w_accept) begin
          wr_d   = 1'b1;
          data_d = snk_data_i;
          if (snk_sop_i) begin
            // Restart: this beat becomes pixel 0 of a fresh frame.
            err_d  = 1'b1;
            addr_d = '0;
            cnt_d  = c_ONE;
          end else begin
            addr_d = cnt_q;
            if (cnt_q == c_LAST) begin
              state_d = S_FLUSH;
              cnt_d   = '0;
              if (!snk_eop_i) err_d = 1'b1;
            end else if (snk_eop_i) begin
              state_d = S_WAIT_SOP;
              err_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + c_ONE;
            end
          end
        end
      end

      S_FLUSH: begin
        cnt_d   = '0;
        state_d = load_en_i ? S_DONE : S_IDLE;
      end

      S_DONE: begin
        if (!load_en_i) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign mem_wr_o         = wr_q;
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = data_q;
  assign frame_err_o      = err_q;
  assign input_received_o = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_edge_pixel_loader.sv
`default_nettype none
// ============================================================================
// tb_edge_pixel_loader : randomized self-checking bench with beat-level model
// Rev 1.0
// ============================================================================
module tb_edge_pixel_loader;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 8;
  localparam int N      = IMG_W * IMG_H;
  localparam int WW     = ADDR_W + PIX_W;

  logic              clk_i       = 1'b0;
  logic              rst_i       = 1'b0;
  logic              load_en_i   = 1'b0;
  logic [PIX_W-1:0]  snk_data_i  = '0;
  logic              snk_valid_i = 1'b0;
  logic              snk_sop_i   = 1'b0;
  logic              snk_eop_i   = 1'b0;
  logic              snk_ready_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [PIX_W-1:0]  mem_data_o;
  logic              input_received_o;
  logic              frame_err_o;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0]    got_q[$];
  logic [WW-1:0]    exp_q[$];
  logic [PIX_W-1:0] bq_d[$];
  logic             bq_s[$];
  logic             bq_e[$];

  // Beat-level reference: frame position and error flag from the framing rules.
  bit m_wait, m_done, m_err;
  int m_idx;

  edge_pixel_loader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .load_en_i       (load_en_i),
    .snk_data_i      (snk_data_i),
    .snk_valid_i     (snk_valid_i),
    .snk_sop_i       (snk_sop_i),
    .snk_eop_i       (snk_eop_i),
    .snk_ready_o     (snk_ready_o),
    .mem_wr_o        (mem_wr_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .input_received_o(input_received_o),
    .frame_err_o     (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_wr_o === 1'b1) got_q.push_back({mem_addr_o, mem_data_o});
  end

  task automatic model_reset();
    m_wait = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_idx  = 0;
    exp_q.delete();
  endtask

  task automatic model_beat(input logic [PIX_W-1:0] d, input logic s, input logic e);
    logic [ADDR_W-1:0] a;
    if (s) begin
      if (!m_wait) m_err = 1'b1;
      a = '0;
      exp_q.push_back({a, d});
      m_wait = 1'b0;
      m_idx  = 1;
    end else if (m_wait) begin
      m_err = 1'b1;
    end else begin
      a = ADDR_W'(m_idx);
      exp_q.push_back({a, d});
      if (m_idx == N - 1) begin
        if (!e) m_err = 1'b1;
        m_done = 1'b1;
      end else if (e) begin
        m_err  = 1'b1;
        m_wait = 1'b1;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic send_beat(input logic [PIX_W-1:0] d, input logic s, input logic e, input int gap);
    bit acc = 1'b0;
    snk_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    snk_data_i  = d;
    snk_sop_i   = s;
    snk_eop_i   = e;
    snk_valid_i = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (snk_ready_o === 1'b1) acc = 1'b1;
      @(posedge clk_i); #1;
    end
    snk_valid_i = 1'b0;
    snk_sop_i   = 1'b0;
    snk_eop_i   = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept timeout: ready=%b required 1", snk_ready_o);
    end else begin
      model_beat(d, s, e);
    end
  endtask

  // gapmode: 0 back-to-back, 1 alternating valid, 2 random gaps
  task automatic drive_beats(input int gapmode);
    int g;
    for (int i = 0; i < bq_d.size(); i++) begin
      if (m_done) break;
      g = (gapmode == 1) ? ((i > 0) ? 1 : 0) :
          (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_beat(bq_d[i], bq_s[i], bq_e[i], g);
    end
    bq_d.delete(); bq_s.delete(); bq_e.delete();
  endtask

  task automatic push_beat(input logic [PIX_W-1:0] d, input logic s, input logic e);
    bq_d.push_back(d); bq_s.push_back(s); bq_e.push_back(e);
  endtask

  task automatic push_frame(input bit rnd, input int base);
    for (int i = 0; i < N; i++)
      push_beat(rnd ? PIX_W'($urandom) : PIX_W'(base + i), i == 0, i == N - 1);
  endtask

  task automatic start_load();
    model_reset();
    got_q.delete();
    load_en_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks += 6;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", snk_ready_o); end
    if (mem_wr_o !== 1'b0) begin errors++; $display("FAIL rst_wr got %b exp 0", mem_wr_o); end
    if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %0h exp 0", mem_addr_o); end
    if (mem_data_o !== '0) begin errors++; $display("FAIL rst_data got %0h exp 0", mem_data_o); end
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL rst_ir got %b exp 0", input_received_o); end
    if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", frame_err_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", snk_ready_o); end
  endtask

  task automatic test_frame(input string nm, input int gapmode, input bit rnd);
    model_reset();
    got_q.delete();
    load_en_i = 1'b1;
    checks++;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL %s idle_ready got %b exp 0", nm, snk_ready_o); end
    @(posedge clk_i); #1;
    checks++;
    if (snk_ready_o !== 1'b1) begin errors++; $display("FAIL %s wait_ready got %b exp 1", nm, snk_ready_o); end
    push_frame(rnd, 'h10);
    drive_beats(gapmode);
    checks += 3;
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL %s ir_early got %b exp 0", nm, input_received_o); end
    if (mem_wr_o !== 1'b1 || mem_addr_o !== ADDR_W'(N - 1))
      begin errors++; $display("FAIL %s last_wr got wr=%b addr=%0h exp wr=1 addr=%0h", nm, mem_wr_o, mem_addr_o, N - 1); end
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL %s flush_ready got %b exp 0", nm, snk_ready_o); end
    @(posedge clk_i); #1;
    checks += 2;
    if (input_received_o !== 1'b1) begin errors++; $display("FAIL %s ir got %b exp 1", nm, input_received_o); end
    if (frame_err_o !== m_err) begin errors++; $display("FAIL %s err got %b exp %b", nm, frame_err_o, m_err); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s wr_count got %0d exp %0d", nm, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s wr[%0d] got %0h exp %0h", nm, i, got_q[i], exp_q[i]); end
    end
    load_en_i = 1'b0;
    checks++;
    if (input_received_o !== 1'b1) begin errors++; $display("FAIL %s ir_hold got %b exp 1", nm, input_received_o); end
    @(posedge clk_i); #1;
    checks++;
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL %s ir_fall got %b exp 0", nm, input_received_o); end
  endtask

  task automatic test_early_eop();
    start_load();
    for (int i = 0; i < 5; i++) push_beat(PIX_W'($urandom), i == 0, i == 4);
    drive_beats(0);
    checks += 2;
    if (frame_err_o !== 1'b1) begin errors++; $display("FAIL eeop_err got %b exp 1", frame_err_o); end
    if (snk_ready_o !== 1'b1) begin errors++; $display("FAIL eeop_ready got %b exp 1", snk_ready_o); end
    push_frame(1'b1, 0);
    drive_beats(2);
    @(posedge clk_i); #1;
    checks += 3;
    if (input_received_o !== 1'b1) begin errors++; $display("FAIL eeop_ir got %b exp 1", input_received_o); end
    if (frame_err_o !== m_err) begin errors++; $display("FAIL eeop_err_end got %b exp %b", frame_err_o, m_err); end
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL eeop_wr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL eeop_wr[%0d] got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    load_en_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_sop_errors();
    start_load();
    for (int i = 0; i < 3; i++) push_beat(PIX_W'($urandom), 1'b0, 1'b0);
    drive_beats(0);
    @(posedge clk_i); #1;
    checks += 2;
    if (got_q.size() !== 0) begin errors++; $display("FAIL nosop_writes got %0d exp 0", got_q.size()); end
    if (frame_err_o !== 1'b1) begin errors++; $display("FAIL nosop_err got %b exp 1", frame_err_o); end
    for (int i = 0; i < 3; i++) push_beat(PIX_W'($urandom), i == 0, 1'b0);
    push_frame(1'b1, 0);
    drive_beats(2);
    @(posedge clk_i); #1;
    checks += 3;
    if (input_received_o !== 1'b1) begin errors++; $display("FAIL midsop_ir got %b exp 1", input_received_o); end
    if (frame_err_o !== m_err) begin errors++; $display("FAIL midsop_err got %b exp %b", frame_err_o, m_err); end
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL midsop_wr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midsop_wr[%0d] got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    load_en_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_abort();
    start_load();
    for (int i = 0; i < 8; i++) push_beat(PIX_W'($urandom), i == 0, 1'b0);
    drive_beats(0);
    load_en_i = 1'b0;
    @(posedge clk_i); #1;
    checks += 3;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", snk_ready_o); end
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL abort_ir got %b exp 0", input_received_o); end
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_wr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL abort_ir_idle got %b exp 0", input_received_o); end
    test_frame("reload", 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    start_load();
    for (int i = 0; i < 10; i++) push_beat(PIX_W'($urandom), i == 0, 1'b0);
    drive_beats(0);
    rst_i = 1'b0;
    #1;
    checks += 5;
    if (snk_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", snk_ready_o); end
    if (mem_wr_o !== 1'b0) begin errors++; $display("FAIL rmid_wr got %b exp 0", mem_wr_o); end
    if (mem_addr_o !== '0) begin errors++; $display("FAIL rmid_addr got %0h exp 0", mem_addr_o); end
    if (mem_data_o !== '0) begin errors++; $display("FAIL rmid_data got %0h exp 0", mem_data_o); end
    if (input_received_o !== 1'b0) begin errors++; $display("FAIL rmid_ir got %b exp 0", input_received_o); end
    load_en_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    test_frame("post_rst", 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int k;
    for (int f = 0; f < 4; f++) begin
      start_load();
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_beat(PIX_W'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(2, N - 2);
        for (int i = 0; i < k; i++) push_beat(PIX_W'($urandom), i == 0, i == k - 1);
      end
      push_frame(1'b1, 0);
      drive_beats($urandom_range(0, 1) * 2);
      @(posedge clk_i); #1;
      checks += 3;
      if (input_received_o !== 1'b1) begin errors++; $display("FAIL b2b%0d_ir got %b exp 1", f, input_received_o); end
      if (frame_err_o !== m_err) begin errors++; $display("FAIL b2b%0d_err got %b exp %b", f, frame_err_o, m_err); end
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b%0d_wr_count got %0d exp %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_wr[%0d] got %0h exp %0h", f, i, got_q[i], exp_q[i]); end
      end
      load_en_i = 1'b0;
      @(posedge clk_i); #1;
      checks++;
      if (input_received_o !== 1'b0) begin errors++; $display("FAIL b2b%0d_ir_fall got %b exp 0", f, input_received_o); end
    end
  endtask

  initial begin
    test_reset();
    test_frame("normal", 0, 1'b0);
    test_frame("gaps", 1, 1'b0);
    test_early_eop();
    test_sop_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_pixel_loader.md
# edge_pixel_loader

Avalon-ST sink that receives one grayscale image frame and writes it, pixel by pixel, into the edge detector's image memory. It sits directly upstream of the edge detector controller and core. The controller enables it during input capture, and the loader reports back with `input_received_o` once the whole frame is stored. It also checks frame framing (SOP/EOP) and discards malformed frames.

## Interface
Parameters:
- `IMG_W`, 16, image width in pixels
- `IMG_H`, 16, image height in pixels
- `PIX_W`, 8, pixel width in bits
- `ADDR_W`, 8, image-memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-low
- `load_en_i`  in  1  level; controller requests frame capture
- `snk_data_i`  in  PIX_W  pixel data
- `snk_valid_i`  in  1  beat valid
- `snk_sop_i`  in  1  first pixel of frame
- `snk_eop_i`  in  1  last pixel of frame
- `snk_ready_o`  out  1  sink ready
- `mem_wr_o`  out  1  image-memory write strobe
- `mem_addr_o`  out  ADDR_W  write address (raster order, row*IMG_W+col)
- `mem_data_o`  out  PIX_W  write data
- `input_received_o`  out  1  full frame stored; held until `load_en_i` falls
- `frame_err_o`  out  1  sticky framing-error flag

## Operation
- N = IMG_W*IMG_H. Pixel counter `cnt` has ADDR_W bits and never exceeds N-1.
- A beat is accepted when `snk_valid_i & snk_ready_o`.
- States: IDLE, WAIT_SOP, LOAD, FLUSH, DONE.
- IDLE:
  - `snk_ready_o`=0, `cnt`=0.
  - `load_en_i`=1 → WAIT_SOP, and `frame_err_o` clears.
- WAIT_SOP:
  - `snk_ready_o`=1.
  - Accepted beat without SOP: dropped, `frame_err_o`←1.
  - Accepted beat with SOP: written to address 0, `cnt`←1, → LOAD.
  - If N=1, an SOP beat must also carry EOP; the loader then goes to FLUSH instead.
- LOAD:
  - `snk_ready_o`=1; each accepted beat is written to address `cnt`, then `cnt`++.
  - SOP in LOAD: `frame_err_o`←1, frame restarts; the beat is written to address 0 and `cnt`←1.
  - EOP with `cnt`<N-1 (early EOP): `frame_err_o`←1, beat is written, `cnt`←0, → WAIT_SOP. The frame is discarded and overwritten by the next one.
  - Beat with `cnt`=N-1 → FLUSH. If EOP is absent on that beat, `frame_err_o`←1 but the frame is still accepted.
- FLUSH: `snk_ready_o`=0; the final registered write is issued this cycle; → DONE.
- DONE:
  - `snk_ready_o`=0, `input_received_o`=1.
  - `load_en_i`=0 → IDLE.
- `load_en_i` falling in WAIT_SOP, LOAD or FLUSH: → IDLE, `cnt`←0, no `input_received_o`. A write already registered still completes on the next cycle.
- Priority (highest first): reset, `load_en_i`=0, SOP restart, EOP/last-pixel checks.
- Pixel data is passed unchanged; no arithmetic besides the counter.

## Timing
- Reset values: `snk_ready_o`=0, `mem_wr_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `input_received_o`=0, `frame_err_o`=0, state IDLE.
- Reset mid-frame aborts immediately; the partial frame is discarded.
- `snk_ready_o` is a combinational decode of the state only (no input dependency); ready latency 0.
- Write path is registered: a beat accepted at edge k drives `mem_wr_o`=1, `mem_addr_o`, `mem_data_o` during cycle k+1.
- The final pixel is accepted at edge k → FLUSH, with that pixel's write occurring in cycle k+1 → `input_received_o`=1 from cycle k+2.
  - This guarantees memory holds all N pixels before the controller proceeds.
- `input_received_o` falls one cycle after `load_en_i` falls.
- `snk_valid_i` gaps are allowed anywhere; `cnt` holds during gaps.
- Throughput: one pixel per cycle. Frame-to-frame minimum: N+3 cycles (load, FLUSH, DONE, IDLE→WAIT_SOP).

## Test plan
Use IMG_W=4, IMG_H=4 (N=16) unless noted.
- **Normal frame:** `load_en_i`=1, 16 back-to-back beats with data 0x10..0x1F, SOP on first, EOP on last → 16 writes to addresses 0..15 with matching data. `input_received_o` rises 2 cycles after the last beat; `frame_err_o`=0.
- **Valid gaps:** same frame with `snk_valid_i` toggling 1010… → identical memory contents; `input_received_o` rises 2 cycles after the last beat.
- **Early EOP:** EOP on beat 5 (addr 4) → `frame_err_o`=1, return to WAIT_SOP. A following good frame overwrites addresses 0..15, then `input_received_o`=1.
- **Missing SOP / mid-frame SOP:**
  - 3 leading beats without SOP → no writes, `frame_err_o`=1.
  - SOP at beat 7 → that beat is written to addr 0, and the next 15 beats complete the frame.
- **Abort:** drop `load_en_i` after 8 beats → IDLE, `input_received_o` stays 0, and `snk_ready_o`=0 next cycle. Re-asserting `load_en_i` plus a full frame → normal completion.
- **Reset mid-frame:** assert `rst_i`=0 after 10 beats → all outputs 0 immediately. After release, a full frame loads correctly from address 0.
